// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Fetch-stage branch predictor. Pre-decodes beq/bne in F,
//                predicts from a table of saturating counters (bimodal when
//                GHR_W = 0, gshare otherwise), carries the prediction into D
//                and trains on the D-stage resolution. Defining BP_RAS_EN adds
//                a return-address stack that predicts `jr $ra` targets
//                (RAS_DEPTH must then be a power of two, at least 2).
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module branch_predictor #(
   parameter int ENTRIES   = 64,
   parameter int CTR_W     = 2,
   parameter int GHR_W     = 6,
   parameter int RAS_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        flushD,
   input  logic [31:0] pcF,
   input  logic [31:0] instrF,
   output logic [31:0] predict_pc,
   output logic        takenD,
   input  logic        updD,
   input  logic        actual_takenD,
   output logic        mispredictD,
   output logic        jr_predD,
   output logic [31:0] jr_targetD
);

   localparam int               c_IDX_W    = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0] c_CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] c_CTR_MAX  = {CTR_W{1'b1}};

   // ------------------------------------------------------------------
   // F-stage pre-decode and target arithmetic
   // ------------------------------------------------------------------
   logic [5:0]  w_op;
   logic        w_brF;
   logic [31:0] w_pcPlus4;
   logic [31:0] w_brTarget;
   logic        w_unused;

   assign w_op       = instrF[31:26];
   assign w_brF      = (w_op == 6'b000100) | (w_op == 6'b000101);
   assign w_pcPlus4  = pcF + 32'd4;
   assign w_brTarget = w_pcPlus4 + {{14{instrF[15]}}, instrF[15:0], 2'b00};
   assign w_unused   = &{1'b0, instrF[25:16]};

   // ------------------------------------------------------------------
   // Counter table (asynchronous read) and D-stage prediction register
   // ------------------------------------------------------------------
   logic [CTR_W-1:0]   r_ctr [ENTRIES];
   logic [c_IDX_W-1:0] w_idxF;
   logic               w_predF;
   logic               r_brvalidD;
   logic               r_takenD;
   logic [c_IDX_W-1:0] r_idxD;
   logic               w_commit;
   logic               w_rasHit;
   logic [31:0]        w_rasTop;

   assign w_predF     = w_brF & r_ctr[w_idxF][CTR_W-1];
   assign w_commit    = updD & en & r_brvalidD;
   assign takenD      = r_takenD;
   assign mispredictD = updD & r_brvalidD & (r_takenD != actual_takenD);

   // Index generation: plain PC bits, optionally hashed with global history
   generate
      if (GHR_W > 0) begin : g_gshare
         logic [GHR_W-1:0] r_ghr;

         assign w_idxF = pcF[c_IDX_W+1:2] ^ c_IDX_W'(r_ghr);

         // Shift resolved direction into history on every committed update
         always_ff @(posedge clk) begin
            if (reset) begin
               r_ghr <= '0;
            end else if (w_commit) begin
               r_ghr <= GHR_W'({r_ghr, actual_takenD});
            end
         end
      end else begin : g_bimodal
         assign w_idxF = pcF[c_IDX_W+1:2];
      end
   endgenerate

   // Next fetch PC: predicted-taken branch beats RAS, default is fall-through
   always_comb begin
      predict_pc = w_pcPlus4;
      if (w_predF) begin
         predict_pc = w_brTarget;
      end else if (w_rasHit) begin
         predict_pc = w_rasTop;
      end
   end

   // F->D prediction register: flush squashes, stall holds
   always_ff @(posedge clk) begin
      if (reset || flushD) begin
         r_brvalidD <= 1'b0;
         r_takenD   <= 1'b0;
         r_idxD     <= '0;
      end else if (en) begin
         r_brvalidD <= w_brF;
         r_takenD   <= w_predF;
         r_idxD     <= w_idxF;
      end
   end

   // Saturating counter training from the D-stage resolution
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_ctr[i] <= c_CTR_INIT;
         end
      end else if (w_commit) begin
         if (actual_takenD) begin
            if (r_ctr[r_idxD] != c_CTR_MAX) begin
               r_ctr[r_idxD] <= r_ctr[r_idxD] + CTR_W'(1);
            end
         end else if (r_ctr[r_idxD] != '0) begin
            r_ctr[r_idxD] <= r_ctr[r_idxD] - CTR_W'(1);
         end
      end
   end

`ifdef BP_RAS_EN
   // ------------------------------------------------------------------
   // Return-address stack: circular, speculative at fetch, never repaired
   // ------------------------------------------------------------------
   localparam int                c_RAS_AW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [c_RAS_AW:0] c_RAS_FULL = (c_RAS_AW + 1)'(RAS_DEPTH);

   logic [31:0]         r_ras [RAS_DEPTH];
   logic [c_RAS_AW-1:0] r_rasPtr;      // next free slot
   logic [c_RAS_AW:0]   r_rasCnt;
   logic [c_RAS_AW-1:0] w_topPtr;
   logic                w_jalF;
   logic                w_jrraF;
   logic                r_jrvalidD;
   logic [31:0]         r_jrTargetD;

   assign w_jalF     = (w_op == 6'b000011);
   assign w_jrraF    = (w_op == 6'b000000) & (instrF[5:0] == 6'b001000) & (instrF[25:21] == 5'd31);
   assign w_topPtr   = r_rasPtr - c_RAS_AW'(1);
   assign w_rasTop   = r_ras[w_topPtr];
   assign w_rasHit   = w_jrraF & (r_rasCnt != '0);
   assign jr_predD   = r_jrvalidD;
   assign jr_targetD = r_jrTargetD;

   // Stack storage: a push when full simply overwrites the oldest slot
   always_ff @(posedge clk) begin
      if (en && w_jalF) begin
         r_ras[r_rasPtr] <= w_pcPlus4;
      end
   end

   // Stack pointer and occupancy; occupancy saturates at the depth
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rasPtr <= '0;
         r_rasCnt <= '0;
      end else if (en) begin
         if (w_jalF) begin
            r_rasPtr <= r_rasPtr + c_RAS_AW'(1);
            if (r_rasCnt != c_RAS_FULL) begin
               r_rasCnt <= r_rasCnt + (c_RAS_AW + 1)'(1);
            end
         end else if (w_rasHit) begin
            r_rasPtr <= w_topPtr;
            r_rasCnt <= r_rasCnt - (c_RAS_AW + 1)'(1);
         end
      end
   end

   // D-stage copy of the return prediction, same flush/stall rules as branches
   always_ff @(posedge clk) begin
      if (reset || flushD) begin
         r_jrvalidD  <= 1'b0;
         r_jrTargetD <= '0;
      end else if (en) begin
         r_jrvalidD  <= w_rasHit;
         r_jrTargetD <= w_rasHit ? w_rasTop : 32'd0;
      end
   end
`else
   assign w_rasHit   = 1'b0;
   assign w_rasTop   = '0;
   assign jr_predD   = 1'b0;
   assign jr_targetD = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed, table-driven bench for branch_predictor in bimodal
//                configuration (GHR_W = 0, CTR_W = 2), plus hand sequences for
//                reset, stall/flush and the return-address stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

   localparam logic [31:0] c_BEQ4  = 32'h1022_0004;  // beq  $1,$2,+4
   localparam logic [31:0] c_BNEM2 = 32'h1422_FFFE;  // bne  $1,$2,-2
   localparam logic [31:0] c_NOP   = 32'h0000_0000;
   localparam logic [31:0] c_JAL   = 32'h0C00_0100;
   localparam logic [31:0] c_JRRA  = 32'h03E0_0008;  // jr   $ra

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        flushD;
   logic [31:0] pcF;
   logic [31:0] instrF;
   logic [31:0] predict_pc;
   logic        takenD;
   logic        updD;
   logic        actual_takenD;
   logic        mispredictD;
   logic        jr_predD;
   logic [31:0] jr_targetD;

   int nChecks = 0;
   int nFail   = 0;

   branch_predictor #(
      .ENTRIES   (64),
      .CTR_W     (2),
      .GHR_W     (0),
      .RAS_DEPTH (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .flushD        (flushD),
      .pcF           (pcF),
      .instrF        (instrF),
      .predict_pc    (predict_pc),
      .takenD        (takenD),
      .updD          (updD),
      .actual_takenD (actual_takenD),
      .mispredictD   (mispredictD),
      .jr_predD      (jr_predD),
      .jr_targetD    (jr_targetD)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        flush;
      logic        upd;
      logic        act;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] expPc;
      logic        expTaken;
      logic        expMis;
   } vec_t;

   vec_t vecs[38];

   function automatic vec_t mk(input logic e, input logic f, input logic u, input logic a,
                               input logic [31:0] p, input logic [31:0] i,
                               input logic [31:0] ep, input logic et, input logic em);
      vec_t v;
      v.en = e; v.flush = f; v.upd = u; v.act = a;
      v.pc = p; v.instr = i; v.expPc = ep; v.expTaken = et; v.expMis = em;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic f, input logic u, input logic a,
                        input logic [31:0] p, input logic [31:0] i);
      en = e; flushD = f; updD = u; actual_takenD = a; pcF = p; instrF = i;
   endtask

   initial begin
      // en flush upd act  pc            instr     expPc         taken mis
      vecs[0]  = mk(1, 0, 0, 0, 32'h100, c_BEQ4, 32'h104, 0, 0); // ctr=1 -> not taken
      vecs[1]  = mk(1, 0, 1, 1, 32'h100, c_BEQ4, 32'h104, 0, 1); // ctr 1->2
      vecs[2]  = mk(1, 0, 1, 1, 32'h100, c_BEQ4, 32'h114, 0, 1); // ctr 2->3
      vecs[3]  = mk(1, 0, 0, 0, 32'h100, c_BEQ4, 32'h114, 1, 0);
      vecs[4]  = mk(1, 0, 1, 0, 32'h100, c_BEQ4, 32'h114, 1, 1); // ctr 3->2
      vecs[5]  = mk(1, 0, 0, 0, 32'h100, c_BEQ4, 32'h114, 1, 0);
      for (int k = 6; k < 16; k++)                               // ten taken, saturate at 3
         vecs[k] = mk(1, 0, 1, 1, 32'h100, c_BEQ4, 32'h114, 1, 0);
      vecs[16] = mk(1, 0, 1, 0, 32'h100, c_BEQ4, 32'h114, 1, 1); // 3->2
      vecs[17] = mk(1, 0, 1, 0, 32'h100, c_BEQ4, 32'h114, 1, 1); // 2->1
      vecs[18] = mk(1, 0, 1, 0, 32'h100, c_BEQ4, 32'h104, 1, 1); // 1->0
      for (int k = 19; k < 26; k++)                              // saturate at 0
         vecs[k] = mk(1, 0, 1, 0, 32'h100, c_BEQ4, 32'h104, 0, 0);
      for (int k = 26; k < 29; k++)                              // stalled resolve: no commit
         vecs[k] = mk(0, 0, 1, 1, 32'h100, c_BEQ4, 32'h104, 0, 1);
      vecs[29] = mk(1, 0, 1, 1, 32'h100, c_BEQ4, 32'h104, 0, 1); // single commit 0->1
      vecs[30] = mk(1, 0, 1, 1, 32'h100, c_BEQ4, 32'h104, 0, 1); // 1->2
      vecs[31] = mk(1, 0, 0, 0, 32'h100, c_BEQ4, 32'h114, 0, 0);
      vecs[32] = mk(1, 1, 0, 0, 32'h100, c_BEQ4, 32'h114, 1, 0); // flush the fetched beq
      vecs[33] = mk(1, 0, 1, 0, 32'h104, c_NOP,  32'h108, 0, 0); // squashed: no update
      vecs[34] = mk(1, 0, 0, 0, 32'h100, c_BEQ4, 32'h114, 0, 0); // ctr still 2
      vecs[35] = mk(1, 0, 0, 0, 32'h200, c_BNEM2, 32'h1FC, 1, 0); // aliases idx 0, backward
      vecs[36] = mk(1, 0, 0, 0, 32'hFFFF_FFF0, c_BEQ4, 32'hFFFF_FFF4, 1, 0);
      vecs[37] = mk(1, 0, 0, 0, 32'hFFFF_FFFC, c_NOP, 32'h0000_0000, 0, 0); // wrap

      // Reset state
      reset = 1'b1;
      drive(0, 0, 1, 1, 32'h0, c_NOP);
      tick();
      tick();
      check("reset_takenD", {31'd0, takenD}, 32'd0);
      check("reset_mispredictD", {31'd0, mispredictD}, 32'd0);
      check("reset_jr_predD", {31'd0, jr_predD}, 32'd0);
      check("reset_jr_targetD", jr_targetD, 32'd0);
      reset = 1'b0;

      // Table-driven main sequence
      for (int i = 0; i < 38; i++) begin
         drive(vecs[i].en, vecs[i].flush, vecs[i].upd, vecs[i].act, vecs[i].pc, vecs[i].instr);
         #1;
         check($sformatf("row%0d_predict_pc", i), predict_pc, vecs[i].expPc);
         check($sformatf("row%0d_takenD", i), {31'd0, takenD}, {31'd0, vecs[i].expTaken});
         check($sformatf("row%0d_mispredictD", i), {31'd0, mispredictD}, {31'd0, vecs[i].expMis});
         check($sformatf("row%0d_jr_predD", i), {31'd0, jr_predD}, 32'd0);
         tick();
      end

      // Return-address stack sequences
      reset = 1'b1;
      drive(0, 0, 0, 0, 32'h0, c_NOP);
      tick();
      reset = 1'b0;
`ifdef BP_RAS_EN
      drive(1, 0, 0, 0, 32'h200, c_JAL);
      #1 check("ras_jal_pc", predict_pc, 32'h204);
      tick();
      drive(1, 0, 0, 0, 32'h300, c_JRRA);
      #1 check("ras_jr_pc", predict_pc, 32'h204);
      tick();
      check("ras_jr_predD", {31'd0, jr_predD}, 32'd1);
      check("ras_jr_targetD", jr_targetD, 32'h204);
      drive(1, 0, 0, 0, 32'h304, c_JRRA);
      #1 check("ras_empty_pc", predict_pc, 32'h308);
      tick();
      check("ras_empty_jr_predD", {31'd0, jr_predD}, 32'd0);

      for (int i = 0; i < 9; i++) begin
         drive(1, 0, 0, 0, 32'h1000 + 32'(4 * i), c_JAL);
         tick();
      end
      drive(0, 0, 0, 0, 32'h2000, c_JRRA);                 // stalled: peek, no pop
      #1 check("ras_stall_pc", predict_pc, 32'h1024);
      tick();
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 0, 0, 32'h2000 + 32'(4 * k), c_JRRA);
         #1 check($sformatf("ras_pop%0d_pc", k), predict_pc, 32'h1024 - 32'(4 * k));
         tick();
         check($sformatf("ras_pop%0d_jr_predD", k), {31'd0, jr_predD}, 32'd1);
         check($sformatf("ras_pop%0d_jr_targetD", k), jr_targetD, 32'h1024 - 32'(4 * k));
      end
      drive(1, 0, 0, 0, 32'h3000, c_JRRA);
      #1 check("ras_pop8_pc", predict_pc, 32'h3004);
      tick();
      check("ras_pop8_jr_predD", {31'd0, jr_predD}, 32'd0);
`else
      drive(1, 0, 0, 0, 32'h200, c_JAL);
      #1 check("nras_jal_pc", predict_pc, 32'h204);
      tick();
      drive(1, 0, 0, 0, 32'h300, c_JRRA);
      #1 check("nras_jr_pc", predict_pc, 32'h304);
      tick();
      check("nras_jr_predD", {31'd0, jr_predD}, 32'd0);
      check("nras_jr_targetD", jr_targetD, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Parametrised fetch-stage branch predictor for the 5-stage MIPS pipeline, replacing the single-configuration predictor. It pre-decodes `beq`/`bne` in F and chooses the next fetch PC from a table of saturating counters, indexed bimodally or gshare-style. It carries each prediction into D and trains on the resolution in D. An optional return-address stack predicts `jr $ra` targets.

## Interface
Parameters:
- ENTRIES, 64, counter-table depth; power of two, ≥4; IDX_W = log2(ENTRIES)
- CTR_W, 2, saturating-counter width, 1..4
- GHR_W, 6, global-history length; 0 selects bimodal indexing; GHR_W ≤ IDX_W
- RAS_DEPTH, 8, return-stack entries, power of two (used only with BP_RAS_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  fetch/decode advance (= ~stallF)
- flushD  in  1  squash the F→D prediction register
- pcF  in  32  fetch PC
- instrF  in  32  fetched instruction
- predict_pc  out  32  predicted next fetch PC
- takenD  out  1  prediction carried with the instruction now in D
- updD  in  1  branch in D is resolving this cycle
- actual_takenD  in  1  resolved direction (pcsrcD)
- mispredictD  out  1  updD & brvalidD & (takenD != actual_takenD)
- jr_predD  out  1  D instruction is `jr $ra` with a valid RAS prediction
- jr_targetD  out  32  RAS-predicted target for that `jr`

## Operation
- Pre-decode in F:
  - brF = opcode 000100 or 000101
  - jalF = opcode 000011
  - jrraF = opcode 0, funct 001000, rs = 31
- Index: idxF = pcF[IDX_W+1:2] XOR {zeros, ghr}, with ghr zero-extended to IDX_W. With GHR_W = 0, idxF = pcF[IDX_W+1:2].
- Prediction: predF = brF & ctr[idxF][CTR_W-1]. The counter array is a register array with asynchronous read.
- predict_pc, in priority order:
  - predF: pcF + 4 + (sext(instrF[15:0]) << 2), 32-bit wrap-around
  - RAS enabled, jrraF, RAS non-empty: top of RAS
  - otherwise: pcF + 4
- D register, loaded when en = 1, holding {brvalidD, takenD, idxD, jrvalidD, jr_targetD}:
  - flushD = 1 or reset = 1 clears it to 0
  - en = 0 holds it
- Training commits only when updD & en & brvalidD:
  - ctr[idxD] increments (saturating at 2^CTR_W−1) on taken and decrements (saturating at 0) otherwise
  - ghr <= {ghr[GHR_W-2:0], actual_takenD}
- A read and an update to the same index in one cycle: the read returns the pre-update value.
- mispredictD is combinational and independent of en. The datapath uses it to redirect to the resolved PC.
- Reset:
  - every counter = 2^(CTR_W-1) − 1 (weakly not-taken)
  - ghr = 0, RAS pointer = 0, RAS count = 0
  - all D-register outputs 0
  - jr_targetD = 0

## Timing
- predict_pc is combinational in F: zero-cycle latency from pcF/instrF.
- A counter update is visible to F reads on the cycle after commit.
- takenD, jr_predD and jr_targetD appear one cycle after the corresponding fetch with en = 1.
- Holding updD for several stalled cycles commits once, on the first cycle with en = 1.
- RAS push/pop are speculative at fetch and occur only when en = 1. They are never repaired on flush; the datapath compares jr_targetD against the resolved register value.

## Configuration
- BP_RAS_EN defined:
  - RAS_DEPTH-entry circular stack
  - jalF & en pushes pcF + 4
  - jrraF & en with non-empty stack pops and predicts that value
  - push when full overwrites the oldest entry; count saturates at RAS_DEPTH
  - pop when empty: no prediction, jr_predD = 0
- BP_RAS_EN undefined:
  - no stack logic
  - jr_predD and jr_targetD tied to 0
  - `jr` always predicts pcF + 4

## Test plan
- Reset, GHR_W=0, CTR_W=2; beq at pcF=0x100 with imm=4 → predict_pc=0x104; next cycle takenD=0.
- Resolve that beq taken twice (updD=1, actual_takenD=1, en=1) → counter 3; next fetch at 0x100 gives predict_pc=0x114, takenD=1.
- Counter at 3, resolve not-taken → mispredictD=1 that cycle; counter becomes 2; next prediction is still taken (0x114).
- Ten taken updates → counter stays 3; then ten not-taken → stays 0; mispredictD tracks each.
- Resolve with en=0 for 3 cycles, then en=1 → exactly one counter step, in the en=1 cycle; flushD=1 → brvalidD=0, no update.
- BP_RAS_EN, RAS_DEPTH=8:
  - jal at 0x200, then jr $ra → predict_pc=0x204, jr_predD=1, jr_targetD=0x204
  - nine jals at 0x1000, 0x1004, … 0x1020 → eight pops return 0x1024 down to 0x1008; ninth pop gives jr_predD=0
